// File: rtl/spi_master_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_sequencer_if
// Brief    : Request/grant and SPI timing bundle between the sequencer and
//            its requesters. SPI_SEQ_ABORT_EN adds abort/aborted.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_master_sequencer_if #(
    parameter int NREQ       = 2,
    parameter int FRAME_BITS = 64
);
    logic [NREQ-1:0]                   req;
    logic [NREQ-1:0]                   gnt;
    logic                              busy;
    logic                              done;
    logic [$clog2(FRAME_BITS+1)-1:0]   bit_idx;
    logic                              sample_stb;
    logic                              shift_stb;
    logic                              cs;
    logic                              sclk;
`ifdef SPI_SEQ_ABORT_EN
    logic                              abort;
    logic                              aborted;

    modport master (
        input  req, abort,
        output gnt, busy, done, bit_idx, sample_stb, shift_stb, cs, sclk, aborted
    );
    modport slave (
        output req, abort,
        input  gnt, busy, done, bit_idx, sample_stb, shift_stb, cs, sclk, aborted
    );
`else
    modport master (
        input  req,
        output gnt, busy, done, bit_idx, sample_stb, shift_stb, cs, sclk
    );
    modport slave (
        output req,
        input  gnt, busy, done, bit_idx, sample_stb, shift_stb, cs, sclk
    );
`endif
endinterface
`default_nettype wire

// File: rtl/spi_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_sequencer
// Brief    : Round-robin SPI bus sequencer (CPOL=0/CPHA=0), timing strobes
//            only. Optional SPI_SEQ_ABORT_EN enables frame abort.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_sequencer #(
    parameter int NREQ            = 2,
    parameter int FRAME_BITS      = 64,
    parameter int SCLK_HALFPERIOD = 1,
    parameter int CS_GAP          = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    spi_master_sequencer_if.master      bus
);
    localparam int c_PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_HCNT_W = (SCLK_HALFPERIOD > 1) ? $clog2(SCLK_HALFPERIOD) : 1;
    localparam int c_GCNT_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int c_BIT_W  = $clog2(FRAME_BITS + 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_HIGH  = 3'd2;
    localparam logic [2:0] c_LOW   = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;

    logic [2:0]          r_state, w_state_n;
    logic [c_HCNT_W-1:0] r_hcnt, w_hcnt_n;
    logic [c_GCNT_W-1:0] r_gcnt, w_gcnt_n;
    logic [c_BIT_W-1:0]  r_bit_idx, w_bit_idx_n;
    logic [c_PTR_W-1:0]  r_ptr, w_ptr_n, w_pick;
    logic [NREQ-1:0]     r_gnt, w_gnt_n, w_onehot;
    logic                r_cs, w_cs_n, r_sclk, w_sclk_n, r_busy, w_busy_n;
    logic                r_done, w_done_n, r_sample, w_sample_n, r_shift, w_shift_n;
    logic                w_half_end, w_last_bit;
`ifdef SPI_SEQ_ABORT_EN
    logic                r_aborted, w_aborted_n;
`endif

    // First requester at or above the pointer, wrapping modulo NREQ.
    function automatic logic [c_PTR_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                   input logic [c_PTR_W-1:0] p);
        logic [c_PTR_W-1:0] sel;
        logic               found;
        int                 idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && r[c_PTR_W'(idx)]) begin
                found = 1'b1;
                sel   = c_PTR_W'(idx);
            end
        end
        return sel;
    endfunction

    assign w_half_end = (r_hcnt == c_HCNT_W'(SCLK_HALFPERIOD - 1));
    assign w_last_bit = (r_bit_idx == c_BIT_W'(FRAME_BITS - 1));

    always_comb begin
        w_state_n   = r_state;
        w_hcnt_n    = r_hcnt;
        w_gcnt_n    = r_gcnt;
        w_bit_idx_n = r_bit_idx;
        w_ptr_n     = r_ptr;
        w_gnt_n     = r_gnt;
        w_cs_n      = r_cs;
        w_sclk_n    = r_sclk;
        w_busy_n    = r_busy;
        w_done_n    = 1'b0;
        w_sample_n  = 1'b0;
        w_shift_n   = 1'b0;
`ifdef SPI_SEQ_ABORT_EN
        w_aborted_n = 1'b0;
`endif
        w_pick             = rr_pick(bus.req, r_ptr);
        w_onehot           = '0;
        w_onehot[w_pick]   = 1'b1;

        case (r_state)
            c_IDLE: begin
                w_bit_idx_n = '0;
                if (|bus.req) begin
                    w_state_n = c_SETUP;
                    w_hcnt_n  = '0;
                    w_gnt_n   = w_onehot;
                    w_cs_n    = 1'b0;
                    w_busy_n  = 1'b1;
                    w_ptr_n   = c_PTR_W'((int'(w_pick) + 1) % NREQ);
                end
            end
            c_SETUP, c_LOW: begin
                if (!w_half_end) begin
                    w_hcnt_n = r_hcnt + 1'b1;
                end else if (r_state == c_LOW && w_last_bit) begin
                    w_state_n = c_GAP;
                    w_gcnt_n  = '0;
                    w_cs_n    = 1'b1;
                    w_gnt_n   = '0;
                    w_done_n  = 1'b1;
                end else begin
                    // SETUP and every non-final LOW both open a HIGH phase.
                    w_state_n  = c_HIGH;
                    w_hcnt_n   = '0;
                    w_sclk_n   = 1'b1;
                    w_sample_n = 1'b1;
                    if (r_state == c_LOW) begin
                        w_bit_idx_n = r_bit_idx + 1'b1;
                    end
                end
            end
            c_HIGH: begin
                if (!w_half_end) begin
                    w_hcnt_n = r_hcnt + 1'b1;
                end else begin
                    w_state_n = c_LOW;
                    w_hcnt_n  = '0;
                    w_sclk_n  = 1'b0;
                    w_shift_n = !w_last_bit;
                end
            end
            c_GAP: begin
                if (r_gcnt == c_GCNT_W'(CS_GAP - 1)) begin
                    w_state_n   = c_IDLE;
                    w_busy_n    = 1'b0;
                    w_bit_idx_n = '0;
                end else begin
                    w_gcnt_n = r_gcnt + 1'b1;
                end
            end
            default: begin
                w_state_n   = c_IDLE;
                w_cs_n      = 1'b1;
                w_sclk_n    = 1'b0;
                w_gnt_n     = '0;
                w_busy_n    = 1'b0;
                w_bit_idx_n = '0;
            end
        endcase

`ifdef SPI_SEQ_ABORT_EN
        if (bus.abort && (r_state == c_SETUP || r_state == c_HIGH || r_state == c_LOW)) begin
            w_state_n   = c_GAP;
            w_gcnt_n    = '0;
            w_hcnt_n    = '0;
            w_bit_idx_n = r_bit_idx;
            w_sclk_n    = 1'b0;
            w_cs_n      = 1'b1;
            w_gnt_n     = '0;
            w_sample_n  = 1'b0;
            w_shift_n   = 1'b0;
            w_done_n    = 1'b1;
            w_aborted_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_hcnt    <= '0;
            r_gcnt    <= '0;
            r_bit_idx <= '0;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_cs      <= 1'b1;
            r_sclk    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sample  <= 1'b0;
            r_shift   <= 1'b0;
`ifdef SPI_SEQ_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_hcnt    <= w_hcnt_n;
            r_gcnt    <= w_gcnt_n;
            r_bit_idx <= w_bit_idx_n;
            r_ptr     <= w_ptr_n;
            r_gnt     <= w_gnt_n;
            r_cs      <= w_cs_n;
            r_sclk    <= w_sclk_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
            r_sample  <= w_sample_n;
            r_shift   <= w_shift_n;
`ifdef SPI_SEQ_ABORT_EN
            r_aborted <= w_aborted_n;
`endif
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.bit_idx    = r_bit_idx;
    assign bus.sample_stb = r_sample;
    assign bus.shift_stb  = r_shift;
    assign bus.cs         = r_cs;
    assign bus.sclk       = r_sclk;
`ifdef SPI_SEQ_ABORT_EN
    assign bus.aborted    = r_aborted;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_sequencer
// Brief    : Self-checking bench: grant scoreboard, frame table, corner cases.
//            Abort sequence runs when SPI_SEQ_ABORT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic mon_en;
    logic frame_chk;
    logic prev_cs;
    int   lo_len, n_samp, n_shift;
    logic [1:0] sb_q[$];

    typedef struct {
        logic [1:0] req;
        logic [1:0] exp_gnt;
    } vec_t;
    vec_t tbl[8];

    spi_master_sequencer_if #(.NREQ(2), .FRAME_BITS(8)) bus_a();
    spi_master_sequencer_if #(.NREQ(2), .FRAME_BITS(8)) bus_b();

    spi_master_sequencer #(.NREQ(2), .FRAME_BITS(8), .SCLK_HALFPERIOD(1), .CS_GAP(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );
    spi_master_sequencer #(.NREQ(2), .FRAME_BITS(8), .SCLK_HALFPERIOD(3), .CS_GAP(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for instance A: grant order and per-frame shape.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_cs && !bus_a.cs) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got gnt %0h with no expected grant", bus_a.gnt);
                end else begin
                    check("sb_gnt", {30'd0, bus_a.gnt}, {30'd0, sb_q.pop_front()});
                end
                lo_len  = 0;
                n_samp  = 0;
                n_shift = 0;
            end
            if (!bus_a.cs) begin
                lo_len++;
                n_samp  += int'(bus_a.sample_stb);
                n_shift += int'(bus_a.shift_stb);
                check("gnt_onehot", {31'd0, $onehot(bus_a.gnt)}, 1);
            end else begin
                check("gnt_low_when_cs_high", {30'd0, bus_a.gnt}, 0);
                if (!prev_cs && frame_chk) begin
                    check("cs_low_len", lo_len, 17);
                    check("sample_cnt", n_samp, 8);
                    check("shift_cnt", n_shift, 7);
                    check("done_at_cs_rise", {31'd0, bus_a.done}, 1);
                end
            end
        end
        prev_cs = bus_a.cs;
    end

    task automatic wait_done_idle(input string tag);
        int n;
        n = 0;
        while (!bus_a.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, bus_a.done}, 1);
        @(negedge clk);
        check({tag, "_busy_gap"}, {31'd0, bus_a.busy}, 1);
        check({tag, "_done_pulse"}, {31'd0, bus_a.done}, 0);
        @(negedge clk);
        check({tag, "_busy_idle"}, {31'd0, bus_a.busy}, 0);
        check({tag, "_bit_idx_clr"}, {28'd0, bus_a.bit_idx}, 0);
    endtask

    task automatic run_frame(input logic [1:0] r, input logic [1:0] eg);
        int n;
        n = 0;
        while (bus_a.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        sb_q.push_back(eg);
        bus_a.req = r;
        @(negedge clk);
        bus_a.req = 2'b00;
        check("req_to_cs_fall", {31'd0, bus_a.cs}, 0);
        check("busy_on_grant", {31'd0, bus_a.busy}, 1);
        wait_done_idle("frame");
    endtask

    task automatic wait_bit(input int idx, input string tag);
        int n;
        n = 0;
        while (int'(bus_a.bit_idx) != idx && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reach_bit"}, {28'd0, bus_a.bit_idx}, idx);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin : stim
        int n, hi, lo, bad, s1, s2, ns;
        logic sclk_hist[256];
        logic samp_hist[256];

        tbl[0] = '{2'b01, 2'b01};
        tbl[1] = '{2'b11, 2'b10};
        tbl[2] = '{2'b11, 2'b01};
        tbl[3] = '{2'b10, 2'b10};
        tbl[4] = '{2'b10, 2'b10};
        tbl[5] = '{2'b01, 2'b01};
        tbl[6] = '{2'b01, 2'b01};
        tbl[7] = '{2'b11, 2'b10};

        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        frame_chk = 1'b1;
        prev_cs   = 1'b1;
        lo_len    = 0;
        n_samp    = 0;
        n_shift   = 0;
        rst       = 1'b1;
        bus_a.req = 2'b00;
        bus_b.req = 2'b00;
`ifdef SPI_SEQ_ABORT_EN
        bus_a.abort = 1'b0;
        bus_b.abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_cs", {31'd0, bus_a.cs}, 1);
        check("rst_sclk", {31'd0, bus_a.sclk}, 0);
        check("rst_gnt", {30'd0, bus_a.gnt}, 0);
        check("rst_busy", {31'd0, bus_a.busy}, 0);
        check("rst_done", {31'd0, bus_a.done}, 0);
        check("rst_bit_idx", {28'd0, bus_a.bit_idx}, 0);
        check("rst_strobes", {30'd0, bus_a.sample_stb, bus_a.shift_stb}, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Held req=11: alternate grants with 3-cycle cs-high gaps.
        sb_q.push_back(2'b01);
        sb_q.push_back(2'b10);
        sb_q.push_back(2'b01);
        sb_q.push_back(2'b10);
        bus_a.req = 2'b11;
        @(negedge clk);
        check("held_first_fall", {31'd0, bus_a.cs}, 0);
        for (int g = 0; g < 3; g++) begin
            n = 0;
            while (!bus_a.cs && n < 100) begin
                @(negedge clk);
                n++;
            end
            hi = 0;
            while (bus_a.cs && hi < 100) begin
                @(negedge clk);
                hi++;
            end
            check("held_gap_len", hi, 3);
        end
        bus_a.req = 2'b00;
        wait_done_idle("held");

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].req, tbl[i].exp_gnt);
        end

        // Half-period of 3 on instance B.
        bus_b.req = 2'b01;
        @(negedge clk);
        bus_b.req = 2'b00;
        check("h3_cs_fall", {31'd0, bus_b.cs}, 0);
        check("h3_gnt", {30'd0, bus_b.gnt}, 2'b01);
        lo = 0;
        while (!bus_b.cs && lo < 200) begin
            sclk_hist[lo[7:0]] = bus_b.sclk;
            samp_hist[lo[7:0]] = bus_b.sample_stb;
            lo++;
            @(negedge clk);
        end
        check("h3_cs_low_len", lo, 51);
        check("h3_done", {31'd0, bus_b.done}, 1);
        bad = 0;
        s1  = -1;
        s2  = -1;
        ns  = 0;
        for (int c = 0; c < 51 && c < lo; c++) begin
            if (sclk_hist[c] !== ((c >= 3) && (((c - 3) % 6) < 3))) bad++;
            if (samp_hist[c] === 1'b1) begin
                ns++;
                if (s1 < 0) s1 = c;
                else if (s2 < 0) s2 = c;
            end
        end
        check("h3_sclk_pattern", bad, 0);
        check("h3_first_sample", s1, 3);
        check("h3_sample_spacing", s2 - s1, 6);
        check("h3_sample_cnt", ns, 8);
        repeat (3) @(negedge clk);

        // Reset mid-frame: no done, pointer back to 0.
        frame_chk = 1'b0;
        sb_q.push_back(2'b01);
        bus_a.req = 2'b01;
        @(negedge clk);
        bus_a.req = 2'b00;
        wait_bit(4, "rst_mid");
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_cs", {31'd0, bus_a.cs}, 1);
        check("rstmid_sclk", {31'd0, bus_a.sclk}, 0);
        check("rstmid_gnt", {30'd0, bus_a.gnt}, 0);
        check("rstmid_done", {31'd0, bus_a.done}, 0);
        check("rstmid_busy", {31'd0, bus_a.busy}, 0);
        check("rstmid_bit_idx", {28'd0, bus_a.bit_idx}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_no_done", {31'd0, bus_a.done}, 0);
        frame_chk = 1'b1;
        run_frame(2'b11, 2'b01);

        // Requester drops after grant; another raises mid-frame.
        sb_q.push_back(2'b01);
        bus_a.req = 2'b01;
        @(negedge clk);
        bus_a.req = 2'b00;
        check("drop_cs_fall", {31'd0, bus_a.cs}, 0);
        wait_bit(3, "midraise");
        bus_a.req = 2'b10;
        sb_q.push_back(2'b10);
        wait_done_idle("drop");
        @(negedge clk);
        check("midraise_cs", {31'd0, bus_a.cs}, 0);
        check("midraise_gnt", {30'd0, bus_a.gnt}, 2'b10);
        bus_a.req = 2'b00;
        wait_done_idle("midraise");

`ifdef SPI_SEQ_ABORT_EN
        frame_chk = 1'b0;
        sb_q.push_back(2'b01);
        bus_a.req = 2'b01;
        @(negedge clk);
        bus_a.req = 2'b00;
        n = 0;
        while (!(bus_a.bit_idx == 4'd2 && bus_a.sample_stb) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_at_high", {31'd0, bus_a.sclk}, 1);
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        check("abort_cs", {31'd0, bus_a.cs}, 1);
        check("abort_sclk", {31'd0, bus_a.sclk}, 0);
        check("abort_gnt", {30'd0, bus_a.gnt}, 0);
        check("abort_done", {31'd0, bus_a.done}, 1);
        check("abort_aborted", {31'd0, bus_a.aborted}, 1);
        check("abort_bit_idx", {28'd0, bus_a.bit_idx}, 2);
        @(negedge clk);
        check("abort_gap2_busy", {31'd0, bus_a.busy}, 1);
        check("abort_pulse", {30'd0, bus_a.done, bus_a.aborted}, 0);
        @(negedge clk);
        check("abort_idle", {31'd0, bus_a.busy}, 0);
        frame_chk = 1'b1;
`endif

        repeat (2) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
